// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DROP} arbState_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_IF, SEL_DM} arbSel_t;
endpackage

// File: rtl/mem_arb_sel.sv
// Winner pick between fetch and data requesters.
// MEM_ARB_RR_EN selects alternating priority on conflict; otherwise data always wins.
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic    ifElig,
    input  logic    dmElig,
    input  logic    lastData,
    output arbSel_t sel
);
`ifndef MEM_ARB_RR_EN
    logic unusedLastData;
    assign unusedLastData = lastData;
`endif

    always_comb begin
        sel = SEL_NONE;
        if (ifElig && dmElig) begin
`ifdef MEM_ARB_RR_EN
            sel = lastData ? SEL_IF : SEL_DM;
`else
            sel = SEL_DM;
`endif
        end else if (dmElig) begin
            sel = SEL_DM;
        end else if (ifElig) begin
            sel = SEL_IF;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and memory stages; registers results, derives stalls.
// Optional MEM_ARB_RR_EN: alternating priority on conflict instead of data-first.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    input  logic              ifFlush,
    output logic              ifDone,
    output logic [DATA_W-1:0] ifData,
    input  logic              dmRd,
    input  logic              dmWr,
    input  logic [ADDR_W-1:0] dmAddr,
    input  logic [DATA_W-1:0] dmWData,
    output logic              dmDone,
    output logic [DATA_W-1:0] dmRData,
    output logic              stallF,
    output logic              stallM,
    output logic              memReq,
    output logic              memWr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData
);
    arbState_t state;
    arbSel_t   sel;
    logic      ifElig;
    logic      dmElig;
    logic      lastData;

    // A request seen in its own Done cycle is the one just served, not a new one.
    assign ifElig = ifReq & ~ifDone;
    assign dmElig = (dmRd | dmWr) & ~dmDone;

    assign stallF = ifReq & ~ifDone;
    assign stallM = (dmRd | dmWr) & ~dmDone;

    mem_arb_sel uSel (
        .ifElig   (ifElig),
        .dmElig   (dmElig),
        .lastData (lastData),
        .sel      (sel)
    );

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastData <= 1'b0;
        end else if (state == IDLE && sel == SEL_DM) begin
            lastData <= 1'b1;
        end else if (state == IDLE && sel == SEL_IF) begin
            lastData <= 1'b0;
        end
    end
`else
    assign lastData = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            memReq   <= 1'b0;
            memWr    <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
            ifDone   <= 1'b0;
            dmDone   <= 1'b0;
            ifData   <= '0;
            dmRData  <= '0;
        end else begin
            ifDone <= 1'b0;
            dmDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel == SEL_DM) begin
                        memReq   <= 1'b1;
                        memWr    <= dmWr;   // rd+wr together is treated as a write
                        memAddr  <= dmAddr;
                        memWData <= dmWData;
                        state    <= BUSY_D;
                    end else if (sel == SEL_IF) begin
                        memReq  <= 1'b1;
                        memWr   <= 1'b0;
                        memAddr <= ifAddr;
                        state   <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (memAck) begin
                        memReq <= 1'b0;
                        state  <= IDLE;
                        if (!ifFlush) begin
                            ifData <= memRData;
                            ifDone <= 1'b1;
                        end
                    end else if (ifFlush) begin
                        state <= DROP;
                    end
                end
                BUSY_D: begin
                    if (memAck) begin
                        memReq <= 1'b0;
                        memWr  <= 1'b0;
                        dmDone <= 1'b1;
                        state  <= IDLE;
                        if (!memWr) begin
                            dmRData <= memRData;
                        end
                    end
                end
                DROP: begin
                    // Memory cannot be cancelled; wait out the ack and discard it.
                    if (memAck) begin
                        memReq <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
